ceil_math_unit: RTL and testbench
=================================

CEIL_MATH_UNIT -- requirements
Module: ceil_math_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; WIDTH >= 2.
REQ-002 The block SHALL have local parameter CNT_W = $clog2(WIDTH+1), giving the iteration/count width.
REQ-003 The block SHALL have clk_i  input  1  clock; one clock domain; all state on its rising edge.
REQ-004 The block SHALL have rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 The block SHALL have flush_i  input  1  synchronous abort of any in-flight operation.
REQ-006 The block SHALL have valid_i  input  1  request valid.
REQ-007 The block SHALL have ready_o  output  1  block can accept a request.
REQ-008 The block SHALL have op_i  input  1  operation select: 0 = CEIL_DIV, 1 = CLOG2.
REQ-009 The block SHALL have a_i  input  WIDTH  unsigned dividend (CEIL_DIV) or argument (CLOG2).
REQ-010 The block SHALL have b_i  input  WIDTH  unsigned divisor; ignored for CLOG2.
REQ-011 The block SHALL have valid_o  output  1  result valid.
REQ-012 The block SHALL have ready_i  input  1  consumer accepts result.
REQ-013 The block SHALL have result_o  output  WIDTH  result.
REQ-014 The block SHALL have err_o  output  1  divide-by-zero flag, qualified by valid_o.

Function
REQ-015 The FSM SHALL have states IDLE, DIV, CLOG, DONE; ready_o = (state == IDLE); valid_o = (state == DONE).
REQ-016 Acceptance SHALL occur on a clock edge with valid_i && ready_o; a_i, b_i and op_i are registered then, and later input changes have no effect.
REQ-017 CEIL_DIV with b != 0 SHALL go IDLE->DIV: WIDTH radix-2 restoring-division steps, one per cycle, counted by a CNT_W counter.
REQ-018 On the last DIV step the FSM SHALL go to DONE with result_o = quotient + (remainder != 0); this never overflows.
REQ-019 CEIL_DIV with b != 0 SHALL first assert valid_o exactly WIDTH+1 cycles after the acceptance cycle.
REQ-020 CEIL_DIV with b == 0 SHALL go IDLE->DONE directly with result_o = all ones and err_o = 1; valid_o is asserted 1 cycle after acceptance.
REQ-021 CEIL_DIV with a == 0 and b != 0 SHALL give result 0 with the normal WIDTH+1 latency.
REQ-022 CLOG2 SHALL load tmp = a-1 on acceptance, with tmp = 0 when a == 0; a == 0 and a == 1 both give result 0.
REQ-023 In CLOG, if tmp == 0 the FSM SHALL go to DONE, else tmp >>= 1 and count++; result_o = count zero-extended to WIDTH, with maximum value WIDTH.
REQ-024 CLOG2 SHALL first assert valid_o exactly result+2 cycles after the acceptance cycle (variable latency).
REQ-025 err_o SHALL be 0 for every CLOG2 result and for every CEIL_DIV with b != 0.
REQ-026 In DONE, result_o, err_o and valid_o SHALL hold stable until valid_o && ready_i; that edge returns the FSM to IDLE.
REQ-027 No new request SHALL be accepted in the handshake cycle; the next acceptance is possible 1 cycle later.
REQ-028 flush_i SHALL return the FSM to IDLE on the next edge from any state, cleared to reset values; an in-flight result is discarded.
REQ-029 flush_i SHALL take priority over acceptance and over the output handshake.
REQ-030 valid_i while ready_o is low SHALL be ignored and SHALL not be queued.

Reset
REQ-031 While rst_ni is low, independent of clk_i, the block SHALL set state = IDLE, ready_o = 1, valid_o = 0, result_o = 0, err_o = 0, and clear all counters and datapath registers.
REQ-032 Reset asserted mid-operation SHALL abandon the operation immediately; the first acceptance is possible on the first edge after rst_ni rises.

Verification
REQ-033 (WIDTH=8) CEIL_DIV 7/2 -> result_o=4, err_o=0, valid_o first high 9 cycles after acceptance; then 6/3 -> 2; 255/1 -> 255; 0/5 -> 0.
REQ-034 (WIDTH=8) CEIL_DIV 200/0 -> result_o=8'hFF, err_o=1, valid_o 1 cycle after acceptance; the next request 10/3 -> 4 with err_o=0.
REQ-035 (WIDTH=8) CLOG2 for a = 0,1,2,5,128,129,255 -> 0,0,1,3,7,8,8; each valid_o at result+2 cycles after acceptance.
REQ-036 (WIDTH=8) Backpressure: ready_i low for 5 cycles in DONE -> result_o, err_o stable, ready_o=0, a valid_i pulse then is ignored; ready_i high -> IDLE next cycle, only one result delivered.
REQ-037 (WIDTH=8) flush_i pulse in the 4th DIV cycle -> IDLE next edge, valid_o never asserted; a following CLOG2 of a=16 -> 4 is correct.
REQ-038 (WIDTH=8) rst_ni low asynchronously mid-CLOG2 -> outputs at reset values without a clock edge; after release, CEIL_DIV 9/4 -> 3.

Source files
------------

// File: rtl/ceil_math_unit.sv
// ceil_math_unit: multi-cycle unsigned ceiling division and ceiling log2.
//
// CEIL_DIV runs a radix-2 restoring divider for WIDTH steps and rounds the
// quotient up when a remainder is left. CLOG2 counts right shifts of (a-1)
// until it reaches zero, which is the bit length of a-1, i.e. ceil(log2(a)).
// Results are held in DONE under a valid/ready handshake.
module ceil_math_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic             op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             err_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      CLOG = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;

   // Divider datapath: quo starts as the dividend and fills with quotient
   // bits from the right while the dividend bits shift out of the top.
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvs;

   // CLOG2 working value (a-1, shifted right once per step).
   logic [WIDTH-1:0] tmp;

   // Shared step counter: division step index or CLOG2 shift count.
   logic [CNT_W-1:0] cnt;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             step_fits;
   logic [WIDTH-1:0] quo_next;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] ceil_q;
   logic             last_step;

   // One restoring-division step, plus the rounded-up quotient for the last step.
   always_comb begin
      // NOTE: every signal driven here is assigned on every path, so no latches.
      shifted   = {rem, quo[WIDTH-1]};
      trial     = shifted - {1'b0, dvs};
      // The partial remainder is always below 2*divisor, so a clear top bit
      // of the (WIDTH+1)-bit difference means the divisor fitted.
      step_fits = ~trial[WIDTH];
      quo_next  = {quo[WIDTH-2:0], step_fits};
      rem_next  = step_fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      // A non-zero remainder implies quotient < a <= max, so +1 cannot wrap.
      ceil_q    = quo_next + WIDTH'(rem_next != '0);
      last_step = (cnt == CNT_W'(WIDTH - 1));
   end

   // Handshake flags decode straight from the registered state.
   assign ready_o = (state == IDLE);
   assign valid_o = (state == DONE);

   // Control FSM and datapath registers; flush behaves like a synchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_ni) begin
         state    <= IDLE;
         quo      <= '0;
         rem      <= '0;
         dvs      <= '0;
         tmp      <= '0;
         cnt      <= '0;
         result_o <= '0;
         err_o    <= 1'b0;
      end else if (flush_i) begin
         state    <= IDLE;
         quo      <= '0;
         rem      <= '0;
         dvs      <= '0;
         tmp      <= '0;
         cnt      <= '0;
         result_o <= '0;
         err_o    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_i) begin
                  cnt   <= '0;
                  err_o <= 1'b0;
                  if (op_i) begin
                     tmp   <= (a_i == '0) ? '0 : a_i - WIDTH'(1);
                     state <= CLOG;
                  end else if (b_i == '0) begin
                     result_o <= '1;
                     err_o    <= 1'b1;
                     state    <= DONE;
                  end else begin
                     quo   <= a_i;
                     rem   <= '0;
                     dvs   <= b_i;
                     state <= DIV;
                  end
               end
            end

            DIV: begin
               quo <= quo_next;
               rem <= rem_next;
               cnt <= cnt + CNT_W'(1);
               if (last_step) begin
                  result_o <= ceil_q;
                  state    <= DONE;
               end
            end

            CLOG: begin
               if (tmp == '0) begin
                  result_o <= WIDTH'(cnt);
                  state    <= DONE;
               end else begin
                  tmp <= tmp >> 1;
                  cnt <= cnt + CNT_W'(1);
               end
            end

            DONE: begin
               if (ready_i) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ceil_math_unit.sv
// tb_ceil_math_unit: directed and random checks of ceil_math_unit (WIDTH=8)
// against an arithmetic reference model.
module tb_ceil_math_unit;

   localparam int WIDTH = 8;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             flush_i = 1'b0;
   logic             valid_i = 1'b0;
   logic             ready_o;
   logic             op_i = 1'b0;
   logic [WIDTH-1:0] a_i = '0;
   logic [WIDTH-1:0] b_i = '0;
   logic             valid_o;
   logic             ready_i = 1'b1;
   logic [WIDTH-1:0] result_o;
   logic             err_o;

   int n_checks = 0;
   int n_fail   = 0;

   ceil_math_unit #(.WIDTH(WIDTH)) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .flush_i  (flush_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .result_o (result_o),
      .err_o    (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: plain arithmetic on the operands.
   function automatic int model_clog(input int a);
      int r = 0;
      while ((1 << r) < a) r++;
      return r;
   endfunction

   task automatic model(input bit op, input int a, input int b,
                        output int res, output bit err, output int lat);
      if (op) begin
         res = model_clog(a);
         err = 1'b0;
         lat = res + 2;
      end else if (b == 0) begin
         res = (1 << WIDTH) - 1;
         err = 1'b1;
         lat = 1;
      end else begin
         res = (a + b - 1) / b;
         err = 1'b0;
         lat = WIDTH + 1;
      end
   endtask

   // Present a request at the negedge; returns #1 after the acceptance edge,
   // with the inputs scrambled to prove they are not sampled again.
   task automatic accept(input bit op, input int a, input int b);
      int w = 0;
      @(negedge clk_i);
      while (!ready_o && w < 50) begin
         @(negedge clk_i);
         w++;
      end
      if (w >= 50) check("ready_timeout", 0, 1);
      valid_i = 1'b1;
      op_i    = op;
      a_i     = WIDTH'(a);
      b_i     = WIDTH'(b);
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      op_i    = 1'($urandom);
      a_i     = WIDTH'($urandom);
      b_i     = WIDTH'($urandom);
   endtask

   // Count cycles after acceptance until valid_o, bounded.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!valid_o && lat < 100) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
   endtask

   // Full transaction: accept, check latency/result/err, then (if ready_i) handshake.
   task automatic run_check(input string tag, input bit op, input int a, input int b);
      int exp_res, exp_lat, lat;
      bit exp_err;
      model(op, a, b, exp_res, exp_err, exp_lat);
      accept(op, a, b);
      if (exp_lat > 1) check({tag, "_busy"}, ready_o, 0);
      wait_valid(lat);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_res"}, result_o, exp_res);
      check({tag, "_err"}, err_o, exp_err);
      if (ready_i) begin
         @(posedge clk_i);
         #1;
         check({tag, "_hs_valid"}, valid_o, 0);
         check({tag, "_hs_ready"}, ready_o, 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] held_res;
      logic             held_err;
      bit               seen;
      int               clog_a[7] = '{0, 1, 2, 5, 128, 129, 255};

      // Reset state
      #12;
      check("rst_ready", ready_o, 1);
      check("rst_valid", valid_o, 0);
      check("rst_result", result_o, 0);
      check("rst_err", err_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Directed CEIL_DIV
      run_check("div_7_2", 1'b0, 7, 2);
      run_check("div_6_3", 1'b0, 6, 3);
      run_check("div_255_1", 1'b0, 255, 1);
      run_check("div_0_5", 1'b0, 0, 5);
      run_check("div_200_0", 1'b0, 200, 0);
      run_check("div_10_3", 1'b0, 10, 3);
      run_check("div_255_255", 1'b0, 255, 255);
      run_check("div_1_255", 1'b0, 1, 255);

      // Directed CLOG2
      foreach (clog_a[i]) run_check($sformatf("clog_%0d", clog_a[i]), 1'b1, clog_a[i], 0);

      // Backpressure: hold result in DONE, ignored request, single delivery
      ready_i = 1'b0;
      run_check("bp", 1'b0, 100, 7);
      held_res = result_o;
      held_err = err_o;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            @(negedge clk_i);
            valid_i = 1'b1;
            op_i    = 1'b1;
            a_i     = 8'd200;
         end
         @(posedge clk_i);
         #1;
         valid_i = 1'b0;
         check("bp_valid", valid_o, 1);
         check("bp_ready", ready_o, 0);
         check("bp_res", result_o, held_res);
         check("bp_err", err_o, held_err);
      end
      @(negedge clk_i);
      ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      check("bp_release_ready", ready_o, 1);
      check("bp_release_valid", valid_o, 0);
      seen = 1'b0;
      repeat (15) begin
         @(posedge clk_i);
         #1;
         if (valid_o) seen = 1'b1;
      end
      check("bp_no_queue", seen, 0);

      // Flush in the 4th DIV cycle
      accept(1'b0, 7, 2);
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      flush_i = 1'b1;
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      check("flush_ready", ready_o, 1);
      check("flush_valid", valid_o, 0);
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk_i);
         #1;
         if (valid_o) seen = 1'b1;
      end
      check("flush_no_result", seen, 0);
      run_check("flush_clog_16", 1'b1, 16, 0);

      // Asynchronous reset mid-CLOG2
      accept(1'b1, 255, 0);
      repeat (3) @(posedge clk_i);
      #3;
      rst_ni = 1'b0;
      #1;
      check("arst_ready", ready_o, 1);
      check("arst_valid", valid_o, 0);
      check("arst_result", result_o, 0);
      check("arst_err", err_o, 0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      run_check("arst_div_9_4", 1'b0, 9, 4);

      // Random mix
      for (int i = 0; i < 40; i++) begin
         bit op;
         int a, b;
         op = 1'($urandom);
         a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 255));
         b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
         run_check($sformatf("rnd%0d_op%0d_%0d_%0d", i, op, a, b), op, a, b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
